// File: rtl/audio_pkg.sv
// Shared types and constants for the PSG frame sequencer and envelope engine.
package audio_pkg;

  localparam int unsigned VOL_W  = 4;
  localparam int unsigned CAND_W = VOL_W + 1;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned REG_W  = 8;

  localparam logic [STEP_W-1:0] STEP_ENV     = 3'd7;
  localparam logic [STEP_W-1:0] SWEEP_STEP_A = 3'd2;
  localparam logic [STEP_W-1:0] SWEEP_STEP_B = 3'd6;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [VOL_W-1:0] vol;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             running;
  } env_state_t;

  // Envelope state loaded from an NRx2 value on trigger.
  function automatic env_state_t env_load(input logic [REG_W-1:0] reg_val);
    env_state_t s;
    s.vol     = reg_val[7:4];
    s.cnt     = reg_val[2:0];
    s.dir     = reg_val[3];
    s.running = |reg_val[2:0];
    return s;
  endfunction

endpackage

// File: rtl/frame_sequencer.sv
// 8-step frame sequencer: divides the 512 Hz strobe into length, sweep and envelope ticks.
module frame_sequencer
  import audio_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic master_en,
  input  logic tick_512,
  output logic length_tick,
  output logic sweep_tick,
  output logic env_tick
);

  logic [STEP_W-1:0] step;

  // Ticks decode the step value before it advances.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step        <= '0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else if (!master_en) begin
      step        <= '0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else begin
      length_tick <= tick_512 && !step[0];
      sweep_tick  <= tick_512 && ((step == SWEEP_STEP_A) || (step == SWEEP_STEP_B));
      env_tick    <= tick_512 && (step == STEP_ENV);
      if (tick_512) step <= step + STEP_W'(1);
    end
  end

endmodule

// File: rtl/envelope_scheduler.sv
// Frame sequencer plus a time-shared volume-envelope engine serving one channel per clock.
module envelope_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned NUM_CH = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    master_en,
  input  logic                    tick_512,
  input  logic [REG_W*NUM_CH-1:0] nrx2,
  input  logic [NUM_CH-1:0]       trigger,
  output logic                    length_tick,
  output logic                    sweep_tick,
  output logic                    env_tick,
  output logic [VOL_W*NUM_CH-1:0] volume,
  output logic [NUM_CH-1:0]       dac_en,
  output logic                    busy
);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pending_q, pending_d;
  env_state_t        env_q [NUM_CH];
  env_state_t        env_d [NUM_CH];
  env_state_t        svc_cur, svc_nxt;
  logic [CNT_W-1:0]  svc_period;
  logic [CAND_W-1:0] cand;

  frame_sequencer u_frame_sequencer (
    .clock       (clock),
    .reset_n     (reset_n),
    .master_en   (master_en),
    .tick_512    (tick_512),
    .length_tick (length_tick),
    .sweep_tick  (sweep_tick),
    .env_tick    (env_tick)
  );

  // Next-state, shared inc/dec unit and per-channel write-back.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    env_d      = env_q;
    svc_cur    = '0;
    svc_period = '0;
    cand       = '0;

    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (idx_q == IDX_W'(k)) begin
        svc_cur    = env_q[k];
        svc_period = nrx2[REG_W*k +: CNT_W];
      end
    end

    svc_nxt = svc_cur;
    if (svc_cur.running && (svc_period != '0)) begin
      if (svc_cur.cnt > CNT_W'(1)) begin
        svc_nxt.cnt = svc_cur.cnt - CNT_W'(1);
      end else begin
        svc_nxt.cnt = svc_period;
        cand = svc_cur.dir ? ({1'b0, svc_cur.vol} + CAND_W'(1))
                           : ({1'b0, svc_cur.vol} - CAND_W'(1));
        // Carry/borrow out of the 4-bit range latches the envelope instead of wrapping.
        if (!cand[VOL_W]) svc_nxt.vol     = cand[VOL_W-1:0];
        else              svc_nxt.running = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (env_tick || pending_q) begin
          state_d   = SERVICE;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      SERVICE: begin
        if (env_tick) pending_d = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (idx_q == IDX_W'(k)) env_d[k] = svc_nxt;
        end
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Trigger overrides any service write to the same channel.
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (trigger[k]) env_d[k] = env_load(nrx2[REG_W*k +: REG_W]);
    end

    if (!master_en) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) env_d[k] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) env_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      env_q     <= env_d;
    end
  end

  assign busy = (state_q == SERVICE);

  always_comb begin
    volume = '0;
    dac_en = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      volume[VOL_W*k +: VOL_W] = env_q[k].vol;
      dac_en[k]                = |nrx2[REG_W*k+3 +: 5];
    end
  end

endmodule
